// File: rtl/seq_cmp_pkg.sv
// seq_cmp_pkg: state encodings, result type and elaboration helpers
// shared by the iterative comparator and its slice compare cell.
package seq_cmp_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_res_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_cmp_if.sv
// seq_cmp_if: request/result handshake between a client (master) and the
// iterative comparator (slave).
interface seq_cmp_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;

    modport master (
        output start, x, y, signed_mode,
        input  busy, done, eq, lt, gt
    );

    modport slave (
        input  start, x, y, signed_mode,
        output busy, done, eq, lt, gt
    );

endinterface

// File: rtl/seq_cmp_slice.sv
// cmp_slice: purely combinational W-bit unsigned magnitude compare cell,
// the per-cycle building block of the iterative comparator.
module cmp_slice #(
    parameter int W = 2
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         eq_o,
    output logic         lt_o,
    output logic         gt_o
);

    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i <  b_i);
    assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/seq_cmp.sv
// seq_cmp: iterative MSB-first magnitude comparator, SLICE bits per clock,
// stopping at the first differing slice; signed or unsigned per request.
module seq_cmp
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 2
) (
    input logic      clk,
    input logic      rst_n,
    seq_cmp_if.slave cmp_if
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (clog2(NSLICE) > 1) ? clog2(NSLICE) : 1;

    // Flipping the sign bit of both operands maps two's-complement order
    // onto plain unsigned order, so the slice cells never need a signed mode.
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NSLICE - 1);
    localparam logic [IDXW-1:0]  IDX_ONE  = IDXW'(1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             done_q, done_d;
    cmp_res_t         res_q, res_d;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic             s_eq;
    logic             s_lt;
    logic             s_gt;

    assign a_slice = a_q[int'(idx_q) * SLICE +: SLICE];
    assign b_slice = b_q[int'(idx_q) * SLICE +: SLICE];

    cmp_slice #(
        .W(SLICE)
    ) u_slice (
        .a_i (a_slice),
        .b_i (b_slice),
        .eq_o(s_eq),
        .lt_o(s_lt),
        .gt_o(s_gt)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        res_d   = res_q;

        case (state_q)
            ST_IDLE: begin
                if (cmp_if.start) begin
                    a_d     = cmp_if.x ^ (cmp_if.signed_mode ? MSB_MASK : '0);
                    b_d     = cmp_if.y ^ (cmp_if.signed_mode ? MSB_MASK : '0);
                    idx_d   = IDX_LAST;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!s_eq) begin
                    res_d   = '{eq: 1'b0, lt: s_lt, gt: s_gt};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (idx_q == '0) begin
                    res_d   = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            // NOTE: operand and index registers are reset as well, so an aborted run leaves no stale data.
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign cmp_if.busy = (state_q == ST_RUN);
    assign cmp_if.done = done_q;
    assign cmp_if.eq   = res_q.eq;
    assign cmp_if.lt   = res_q.lt;
    assign cmp_if.gt   = res_q.gt;

endmodule

// File: tb/tb_seq_cmp.sv
// tb_seq_cmp: directed plus randomized stimulus for seq_cmp (WIDTH=8, SLICE=2),
// checked by a scoreboard fed from an arithmetic reference model.
module tb_seq_cmp;

    localparam int WIDTH    = 8;
    localparam int SLICE    = 2;
    localparam int NSLICE   = WIDTH / SLICE;
    localparam int N_RANDOM = 4000;
    localparam int BOUND    = 50;

    typedef struct {
        logic [2:0] res;   // {eq, lt, gt}
        int         k;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [2:0] hold;
    int   busy_cnt;

    seq_cmp_if #(.WIDTH(WIDTH)) bus ();

    seq_cmp #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmp_if(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound of %0d cycles expired at %0t", name, BOUND, $time);
    endtask

    // Reference: compare the numeric values the operands denote; k is how many
    // slices, counted from the top, must be read to reach the first difference.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t e;
        int   ia, ib, sa, sb_v;
        bit   found;
        ia = int'(a);
        ib = int'(b);
        if (s) begin
            if (a[WIDTH-1]) ia = ia - (1 << WIDTH);
            if (b[WIDTH-1]) ib = ib - (1 << WIDTH);
        end
        e.res = {ia == ib, ia < ib, ia > ib};
        e.k   = NSLICE;
        found = 1'b0;
        for (int i = NSLICE - 1; i >= 0; i--) begin
            sa   = (int'(a) >> (i * SLICE)) & ((1 << SLICE) - 1);
            sb_v = (int'(b) >> (i * SLICE)) & ((1 << SLICE) - 1);
            if (!found && sa != sb_v) begin
                found = 1'b1;
                e.k   = NSLICE - i;
            end
        end
        return e;
    endfunction

    // Called at a falling edge; raises start as soon as the block is idle and
    // returns on the falling edge after the accepting rising edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input bit expect_it);
        int guard;
        guard = 0;
        while (bus.busy && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= BOUND) bound_expired("issue_wait_idle");
        bus.x           = a;
        bus.y           = b;
        bus.signed_mode = s;
        bus.start       = 1'b1;
        if (expect_it) sb.push_back(model(a, b, s));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!bus.done && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= BOUND) bound_expired("wait_done");
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= BOUND) bound_expired("drain");
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every done pulse, checks result and the
    // busy length, and checks that results hold steady between completions.
    initial begin
        hold     = '0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold     = '0;
                busy_cnt = 0;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", {31'd0, bus.done}, 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("result_eq_lt_gt", {29'd0, bus.eq, bus.lt, bus.gt}, {29'd0, mon_e.res});
                        check("busy_cycles_k", busy_cnt, mon_e.k);
                        hold = mon_e.res;
                    end
                    busy_cnt = 0;
                end else begin
                    check("result_hold", {29'd0, bus.eq, bus.lt, bus.gt}, {29'd0, hold});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b;
        logic       s;
        int         mode;

        bus.start       = 1'b0;
        bus.x           = '0;
        bus.y           = '0;
        bus.signed_mode = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_outs", {29'd0, bus.eq, bus.lt, bus.gt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Equal operands, early exits, late differences, signed negatives
        issue(8'hA5, 8'hA5, 1'b0, 1'b1);
        issue(8'h80, 8'h7F, 1'b0, 1'b1);
        issue(8'h80, 8'h7F, 1'b1, 1'b1);
        issue(8'h13, 8'h12, 1'b0, 1'b1);
        issue(8'hFF, 8'hFE, 1'b1, 1'b1);
        drain();

        // start while busy is ignored, operands included
        issue(8'h00, 8'h01, 1'b0, 1'b1);
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b1;
        bus.x     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // start raised in the done cycle is accepted at once
        issue(8'h13, 8'h12, 1'b0, 1'b1);
        wait_done();
        check("idle_in_done_cycle", {31'd0, bus.busy}, 32'd0);
        issue(8'h40, 8'h10, 1'b0, 1'b1);
        check("accepted_in_done_cycle", {31'd0, bus.busy}, 32'd1);
        drain();

        // Reset mid-run: outputs clear without waiting for a clock edge
        issue(8'h01, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_outs", {29'd0, bus.eq, bus.lt, bus.gt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(8'h02, 8'h01, 1'b0, 1'b1);
        drain();

        // Randomized compares, issued back to back; inputs are scrambled while
        // busy to show the latched operands are unaffected.
        for (int n = 0; n < N_RANDOM; n++) begin
            mode = int'($urandom_range(0, 3));
            a    = 8'($urandom);
            s    = 1'($urandom);
            case (mode)
                0:       b = a;
                1:       b = a ^ (8'h01 << $urandom_range(0, WIDTH - 1));
                2:       b = {a[7:2], 2'($urandom)};
                default: b = 8'($urandom);
            endcase
            issue(a, b, s, 1'b1);
            bus.x           = 8'($urandom);
            bus.y           = 8'($urandom);
            bus.signed_mode = 1'($urandom);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_cmp.md
Name: seq_cmp

Overview:
- Parametrised, iterative magnitude comparator. Successor to the fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, SLICE bits per clock, in signed or unsigned mode.
- Stops early at the first differing slice and reports eq/lt/gt through a start/busy/done handshake.
- Used in datapaths where wide operands make a single-cycle compare too slow or too large.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SLICE and at least 2.
- SLICE, 2, bits compared per cycle; must be at least 1.
- NSLICE (local), WIDTH/SLICE, number of slices.
- IDXW (local), max(1, clog2(NSLICE)), width of the slice index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when not busy.
- x  in  WIDTH  operand A; captured when start is accepted.
- y  in  WIDTH  operand B; captured when start is accepted.
- signed_mode  in  1  1 = two's-complement compare; captured when start is accepted.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when a result is written.
- eq  out  1  x == y.
- lt  out  1  x < y.
- gt  out  1  x > y.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, eq=0, lt=0, gt=0; operand and index registers cleared.
- States: IDLE, RUN.
- IDLE with start=1:
  - Latch x, y and signed_mode.
  - If signed_mode=1, invert bit WIDTH-1 of both latched operands. Signed order then equals unsigned order of the modified operands.
  - Set idx=NSLICE-1, busy=1, go to RUN.
- RUN, each cycle: compare slice idx ([idx*SLICE +: SLICE]) of both operands with cmp_slice.
  - Slice unequal: register lt/gt from that slice, eq=0. Pulse done next cycle, busy=0, go to IDLE.
  - Slice equal and idx==0: register eq=1, lt=0, gt=0. Pulse done, busy=0, go to IDLE.
  - Otherwise: idx decrements, stay in RUN.
- Latency: done asserts k rising edges after the edge that accepts start. k = number of slices examined, 1 <= k <= NSLICE. busy is high for exactly k cycles.
- Result validity: eq/lt/gt are one-hot once any compare has completed. They hold their value until the next completion and are not cleared by a new start.
- start while busy=1: ignored; operands and the run are unaffected.
- start during the done cycle: accepted, because the block is in IDLE. Back-to-back throughput is one compare per k+1 cycles at best.
- Operand or signed_mode changes while busy: no effect.
- Reset mid-RUN: abort immediately to reset values; no done pulse.
- SLICE == WIDTH: always k=1.
- SLICE == 1: bit-serial operation.

Decomposition:
- Shared include cmp_defs.vh holds:
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1;
  - a clog2 function used for IDXW.
- Sub-module cmp_slice (parameter W): purely combinational W-bit compare producing eq/lt/gt. It generalises the existing 2-bit compare cell.
- Top level contains the FSM, operand registers, index counter, slice mux and result registers.

Test Plan:
- Setup for all cases: WIDTH=8, SLICE=2.
- Equal operands: x=0xA5, y=0xA5, unsigned, start -> done 4 cycles after start, eq=1, lt=0, gt=0, busy high 4 cycles.
- Early exit, unsigned: x=0x80, y=0x7F -> done after 1 cycle, gt=1. Same operands with signed_mode=1 -> done after 1 cycle, lt=1.
- Late difference and signed negatives:
  - x=0x13, y=0x12 unsigned -> done after 4 cycles, gt=1.
  - x=0xFF, y=0xFE signed (-1 vs -2) -> done after 4 cycles, gt=1.
- Handshake:
  - Pulse start with x=0x00, y=0x01, then pulse start again with x=0xFF while busy -> second start ignored; result lt=1 after 4 cycles.
  - start high in the done cycle with x=0x40, y=0x10 -> accepted; gt=1 after 1 further cycle.
- Reset mid-run: start x=0x01, y=0x02, assert rst_n=0 after 2 cycles -> all outputs 0 asynchronously, no done pulse. After release, a new start x=0x02, y=0x01 -> gt=1.
- Exhaustive: all 65536 (x, y) pairs in both modes, checked against a reference model for eq/lt/gt and for k = index of the first differing slice.
